// File: rtl/my_div_controller_if.sv
// Handshake, operand/result and subtractor-port bundle for my_div_controller.
// Optional MY_DIV_SIGNED_EN adds the op_signed request bit.
interface my_div_controller_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef MY_DIV_SIGNED_EN
    logic             op_signed;
`endif
    logic [WIDTH-1:0] sub_a;
    logic [WIDTH-1:0] sub_b;
    logic             sub_c0;
    logic [WIDTH-1:0] sub_res;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Requester side; it also hosts the external subtractor.
    modport master (
        output start, abort, dividend, divisor,
`ifdef MY_DIV_SIGNED_EN
        output op_signed,
`endif
        output sub_res,
        input  sub_a, sub_b, sub_c0,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, abort, dividend, divisor,
`ifdef MY_DIV_SIGNED_EN
        input  op_signed,
`endif
        input  sub_res,
        output sub_a, sub_b, sub_c0,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/my_div_controller.sv
// Restoring divide sequencer that reuses an external subtractor, one bit per clock.
// Optional MY_DIV_SIGNED_EN adds signed operation selected by op_signed.
module my_div_controller #(
    parameter int unsigned WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    my_div_controller_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] div;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dz_q;
`ifdef MY_DIV_SIGNED_EN
    logic             q_neg;
    logic             r_neg;
    logic             neg_a;
    logic             neg_b;
`endif

    logic [WIDTH:0]   shifted;
    logic             qbit;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;
    logic [WIDTH-1:0] dvd_in;
    logic [WIDTH-1:0] dvs_in;
    logic             last;

    // One restoring step; the quotient bit comes from the internal compare only.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        qbit    = (shifted >= {1'b0, div});
        rem_nxt = qbit ? bus.sub_res : shifted[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], qbit};
        last    = (count == CW'(WIDTH - 1));
`ifdef MY_DIV_SIGNED_EN
        neg_a   = bus.op_signed & bus.dividend[WIDTH-1];
        neg_b   = bus.op_signed & bus.divisor[WIDTH-1];
        dvd_in  = neg_a ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
        dvs_in  = neg_b ? (~bus.divisor + WIDTH'(1)) : bus.divisor;
        quo_fin = q_neg ? (~quo_nxt + WIDTH'(1)) : quo_nxt;
        rem_fin = r_neg ? (~rem_nxt + WIDTH'(1)) : rem_nxt;
`else
        dvd_in  = bus.dividend;
        dvs_in  = bus.divisor;
        quo_fin = quo_nxt;
        rem_fin = rem_nxt;
`endif
    end

    // Sequencer and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            div         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
`ifdef MY_DIV_SIGNED_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        div    <= dvs_in;
                        rem    <= '0;
                        quo    <= dvd_in;
                        count  <= '0;
`ifdef MY_DIV_SIGNED_EN
                        q_neg  <= neg_a ^ neg_b;
                        r_neg  <= neg_a;
`endif
                        if (bus.divisor == '0) begin
                            dz_q        <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend;
                            state       <= DONE;
                        end else begin
                            dz_q  <= 1'b0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        rem   <= rem_nxt;
                        quo   <= quo_nxt;
                        count <= count + CW'(1);
                        if (last) begin
                            quotient_q  <= quo_fin;
                            remainder_q <= rem_fin;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Subtractor operands are plain rewiring of state registers.
    assign bus.sub_a       = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign bus.sub_b       = div;
    assign bus.sub_c0      = 1'b0;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dz_q;
endmodule

// File: doc/my_div_controller.md
Name: my_div_controller

Overview:
Sequencer for an unsigned restoring 32/32 division built around the team's external `my_subtractor` instance. The block drives the subtractor's operand ports once per iteration and reads back the difference. It owns the remainder, quotient and divisor registers, the iteration counter and the start/busy/done handshake. It sits beside the ALU and lets a multi-cycle divide reuse the existing subtract datapath instead of a dedicated divider.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH; counter width is clog2(WIDTH)+1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset; one clock; reset is synchronous and active-low
start  input  1  request; sampled only in IDLE
abort  input  1  cancel an operation in progress; no done issued
dividend  input  WIDTH  numerator; latched on an accepted start
divisor  input  WIDTH  denominator; latched on an accepted start
sub_a  output  WIDTH  to subtractor A: trial remainder, low WIDTH bits
sub_b  output  WIDTH  to subtractor B: latched divisor
sub_c0  output  1  to subtractor C0; constant 0
sub_res  input  WIDTH  from subtractor Res: sub_a - sub_b mod 2^WIDTH
busy  output  1  high from the accepting edge until the DONE state exits
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  registered result
remainder  output  WIDTH  registered result
div_by_zero  output  1  registered flag; valid with done, held until the next start

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, count=0.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal rem/quo/div registers are cleared.
  - Reset overrides start and abort, and takes effect mid-operation.
- States:
  - IDLE:
    - start=1 latches the operands.
    - divisor==0: go to DONE with dz=1.
    - Otherwise: rem=0, quo=dividend, count=0, go to RUN.
  - RUN: one iteration per clock, WIDTH iterations in total.
    - shifted = {rem, quo[MSB]}, a WIDTH+1-bit value.
    - sub_a = shifted[WIDTH-1:0]; sub_b = div.
    - If shifted >= {0,div} (internal unsigned compare): rem=sub_res, new q bit=1.
    - Else: rem=shifted[WIDTH-1:0], new q bit=0.
    - quo = {quo[WIDTH-2:0], qbit}; count increments.
    - Leave RUN on the edge where count reaches WIDTH-1.
  - DONE: done=1 for exactly one cycle; quotient/remainder/div_by_zero are loaded on entry; next state is IDLE.
- Quotient-bit decision:
  - Uses only the internal compare, never the subtractor carry.
  - sub_res is used only as the difference.
  - The difference is exact because the result is always < div.
- Latency:
  - Normal divide: done is high in the cycle after edge k+WIDTH+1, where k is the accepting edge (33 edges for WIDTH=32).
  - Divide-by-zero: done is high after edge k+1.
- Divide by zero: quotient=all ones, remainder=dividend, div_by_zero=1.
- start while busy is ignored; operands are not re-latched.
- start is accepted in IDLE the cycle after DONE, so back-to-back operations lose one cycle.
- abort in RUN:
  - Next edge goes to IDLE, busy=0, no done.
  - quotient/remainder outputs keep their previous values.
  - abort in IDLE or DONE is ignored; DONE still completes.
- Outputs hold between operations.
- sub_a and sub_b are don't-care outside RUN; they are driven from registers, so they hold their values.

Optional Feature:
Macro MY_DIV_SIGNED_EN.
- Defined:
  - Adds input port op_signed (1 bit), latched with start.
  - When op_signed=1, operands are converted to magnitudes in the accept cycle.
  - In DONE, the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - -2^(W-1) / -1 yields quotient 0x80000000, remainder 0.
  - Divide-by-zero results are unchanged (all ones, dividend).
  - Latency is unchanged.
- Undefined: port absent, unsigned only.

Test Plan:
- Basic divide: dividend=100, divisor=7, start 1 cycle -> busy=1, done pulses after 33 edges, quotient=14, remainder=2, div_by_zero=0.
- Maximum dividend: dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. Then dividend=5, divisor=0xFFFFFFFF -> quotient=0, remainder=5.
- Divide by zero: dividend=0x1234, divisor=0 -> done 1 edge after start, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1, no RUN cycles.
- Start while busy: start (50/3), then start again at cycle 10 with (9/9) -> second request ignored, result quotient=16, remainder=2, exactly one done.
- Abort and reset mid-operation:
  - abort at iteration 5 -> busy=0 next cycle, no done, outputs keep the prior result.
  - rst_n=0 at iteration 20 -> all outputs 0 the next cycle.
  - A new start after either divides correctly.
- Signed divide (MY_DIV_SIGNED_EN): op_signed=1, -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Then 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
